blood_abnormality_detector: RTL and testbench
=============================================

Name: blood_abnormality_detector

Overview:
- Classifies one blood sample as normal/abnormal from its 4-bit pH code and 3-bit blood-type code.
- Combinational range check by blood group, output registered in the system clock domain.
- Sits between the sample-acquisition front end and the patient-alarm logic. One result per accepted sample.

Parameters:
- AB_PH_MIN, 7, lowest normal pH for group AB (type[2:1]=00)
- AB_PH_MAX, 8, highest normal pH for group AB
- A_PH_MIN, 7, lowest normal pH for group A (type[2:1]=01)
- A_PH_MAX, 8, highest normal pH for group A
- B_PH_MIN, 6, lowest normal pH for group B (type[2:1]=10)
- B_PH_MAX, 7, highest normal pH for group B
- O_PH_MIN, 6, lowest normal pH for group O (type[2:1]=11)
- O_PH_MAX, 7, highest normal pH for group O

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- sampleValid  input  1  bloodPH/bloodType are valid this cycle
- bloodPH  input  4  unsigned pH code, 0..15
- bloodType  input  3  [2:1]=group (00 AB, 01 A, 10 B, 11 O); [0]=Rh (0 +, 1 −)
- resultValid  output  1  bloodAbnormality holds a fresh result this cycle
- bloodAbnormality  output  1  1 = pH outside normal range for group; 0 = normal

Behaviour:
- Reset (rst_n=0, asynchronous): resultValid=0, bloodAbnormality=0, held while rst_n=0.
- Normal iff MIN(group) <= bloodPH <= MAX(group). Both bounds are inclusive and the comparison is unsigned 4-bit.
- Rh bit bloodType[0] is ignored. AB+ and AB−, etc., classify identically.
- Latency is 1 cycle. If sampleValid=1 at edge N, then after edge N resultValid=1 and bloodAbnormality=result, for exactly one cycle.
- If sampleValid=0 at an edge, resultValid goes to 0. bloodAbnormality holds its last value; it does not clear.
- There is no backpressure. A new sample can be accepted every cycle, and back-to-back results are issued every cycle.
- Boundary values: pH 0 and 15 are always abnormal with the default parameters. pH exactly equal to MIN or MAX is normal.
- If a parameter has MIN > MAX, every pH for that group is abnormal. This is legal and must not be flagged as an error.
- Reset asserted mid-stream: the in-flight result is discarded and outputs return to their reset values immediately.
- Inputs are not registered before the comparator. Only the outputs are flopped.

Decomposition:
- Shared package blood_pkg holds:
  - group encoding constants: GRP_AB=2'b00, GRP_A=2'b01, GRP_B=2'b10, GRP_O=2'b11
  - the Rh bit index
  - default pH bound constants used as parameter defaults
- One sub-module: ph_range_checker. It is purely combinational, with MIN/MAX parameters, a 4-bit pH in, and an in_range out.
- The top instantiates four ph_range_checker instances (one per group), a group mux on bloodType[2:1], and the output flops.

Test Plan:
- Reset: hold rst_n=0 with sampleValid=1, type=000, pH=6 → resultValid=0, bloodAbnormality=0; release → result appears one cycle later.
- AB+ (000) at pH 7 → 0. AB+ at pH 6 → 1. AB− (001) at pH 6 → 1 (Rh ignored). AB at pH 8 → 0; pH 9 → 1.
- A+ (010) at pH 7 → 0. A+ at pH 6 → 1. A at pH 8 → 0.
- B+ (100) at pH 7 → 0; pH 5 → 1; pH 6 → 0; pH 8 → 1.
- O+ (110) at pH 7 → 0; pH 5 → 1. O− (111) at pH 6 → 0. Sweep pH 0 and 15 over all 8 types → always 1.
- Streaming: sampleValid=1 for 4 consecutive cycles with mixed samples → 4 consecutive resultValid pulses, each 1 cycle after its input. Drop sampleValid → resultValid=0 and bloodAbnormality holds. Assert rst_n=0 mid-stream → outputs clear asynchronously.

Source files
------------

// File: rtl/blood_pkg.sv
// Shared definitions for the blood abnormality detector: group encoding,
// Rh bit position, default normal-pH windows and the inclusive range test.
package blood_pkg;

  typedef enum logic [1:0] {
    GRP_AB = 2'b00,
    GRP_A  = 2'b01,
    GRP_B  = 2'b10,
    GRP_O  = 2'b11
  } blood_group_e;

  localparam int RH_BIT = 0;

  localparam logic [3:0] DEF_AB_PH_MIN = 4'd7;
  localparam logic [3:0] DEF_AB_PH_MAX = 4'd8;
  localparam logic [3:0] DEF_A_PH_MIN  = 4'd7;
  localparam logic [3:0] DEF_A_PH_MAX  = 4'd8;
  localparam logic [3:0] DEF_B_PH_MIN  = 4'd6;
  localparam logic [3:0] DEF_B_PH_MAX  = 4'd7;
  localparam logic [3:0] DEF_O_PH_MIN  = 4'd6;
  localparam logic [3:0] DEF_O_PH_MAX  = 4'd7;

  // Inclusive unsigned window; an inverted window (lo > hi) matches nothing.
  function automatic logic ph_in_window(input logic [3:0] ph,
                                        input logic [3:0] lo,
                                        input logic [3:0] hi);
    return (ph >= lo) && (ph <= hi);
  endfunction

endpackage

// File: rtl/blood_abnormality_detector_if.sv
// Sample/result bundle between the acquisition front end (master) and the
// abnormality detector (slave).
interface blood_abnormality_detector_if;

  logic       sampleValid;
  logic [3:0] bloodPH;
  logic [2:0] bloodType;
  logic       resultValid;
  logic       bloodAbnormality;

  modport master (
    output sampleValid,
    output bloodPH,
    output bloodType,
    input  resultValid,
    input  bloodAbnormality
  );

  modport slave (
    input  sampleValid,
    input  bloodPH,
    input  bloodType,
    output resultValid,
    output bloodAbnormality
  );

endinterface

// File: rtl/blood_abnormality_detector_ph_range_checker.sv
// Purely combinational check that a 4-bit pH code lies inside [PH_MIN, PH_MAX].
module ph_range_checker
  import blood_pkg::*;
#(
  parameter logic [3:0] PH_MIN = DEF_AB_PH_MIN,
  parameter logic [3:0] PH_MAX = DEF_AB_PH_MAX
) (
  input  logic [3:0] ph,
  output logic       in_range
);

  assign in_range = ph_in_window(ph, PH_MIN, PH_MAX);

endmodule

// File: rtl/blood_abnormality_detector.sv
// Classifies each accepted blood sample as normal/abnormal against the pH
// window of its blood group; result is registered with one cycle of latency.
module blood_abnormality_detector
  import blood_pkg::*;
#(
  parameter logic [3:0] AB_PH_MIN = DEF_AB_PH_MIN,
  parameter logic [3:0] AB_PH_MAX = DEF_AB_PH_MAX,
  parameter logic [3:0] A_PH_MIN  = DEF_A_PH_MIN,
  parameter logic [3:0] A_PH_MAX  = DEF_A_PH_MAX,
  parameter logic [3:0] B_PH_MIN  = DEF_B_PH_MIN,
  parameter logic [3:0] B_PH_MAX  = DEF_B_PH_MAX,
  parameter logic [3:0] O_PH_MIN  = DEF_O_PH_MIN,
  parameter logic [3:0] O_PH_MAX  = DEF_O_PH_MAX
) (
  input  logic                           clk,
  input  logic                           rst_n,
  blood_abnormality_detector_if.slave    bus
);

  logic         ab_in_range;
  logic         a_in_range;
  logic         b_in_range;
  logic         o_in_range;
  logic         grp_in_range;
  blood_group_e grp;
  logic         unused_rh;

  logic result_valid_d, result_valid_q;
  logic abnormal_d,     abnormal_q;

  ph_range_checker #(.PH_MIN(AB_PH_MIN), .PH_MAX(AB_PH_MAX)) u_chk_ab (
    .ph       (bus.bloodPH),
    .in_range (ab_in_range)
  );

  ph_range_checker #(.PH_MIN(A_PH_MIN), .PH_MAX(A_PH_MAX)) u_chk_a (
    .ph       (bus.bloodPH),
    .in_range (a_in_range)
  );

  ph_range_checker #(.PH_MIN(B_PH_MIN), .PH_MAX(B_PH_MAX)) u_chk_b (
    .ph       (bus.bloodPH),
    .in_range (b_in_range)
  );

  ph_range_checker #(.PH_MIN(O_PH_MIN), .PH_MAX(O_PH_MAX)) u_chk_o (
    .ph       (bus.bloodPH),
    .in_range (o_in_range)
  );

  // Rh does not influence classification; only the group bits steer the mux.
  assign grp       = blood_group_e'(bus.bloodType[2:1]);
  assign unused_rh = bus.bloodType[RH_BIT];

  always_comb begin
    grp_in_range = 1'b0;
    unique case (grp)
      GRP_AB:  grp_in_range = ab_in_range;
      GRP_A:   grp_in_range = a_in_range;
      GRP_B:   grp_in_range = b_in_range;
      GRP_O:   grp_in_range = o_in_range;
      default: grp_in_range = 1'b0;
    endcase
  end

  // The abnormality flag only updates on an accepted sample and otherwise holds.
  always_comb begin
    result_valid_d = bus.sampleValid;
    abnormal_d     = abnormal_q;
    if (bus.sampleValid) begin
      abnormal_d = ~grp_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid_q <= 1'b0;
      abnormal_q     <= 1'b0;
    end else begin
      result_valid_q <= result_valid_d;
      abnormal_q     <= abnormal_d;
    end
  end

  assign bus.resultValid      = result_valid_q;
  assign bus.bloodAbnormality = abnormal_q;

endmodule

// File: tb/tb_blood_abnormality_detector.sv
// Directed-vector bench for blood_abnormality_detector with hand-computed
// expectations for the default pH windows.
module tb_blood_abnormality_detector;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  blood_abnormality_detector_if bus ();

  blood_abnormality_detector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btype;
    logic [3:0] ph;
    logic       exp_abn;
  } vec_t;

  vec_t dirVecs[$];
  vec_t streamVecs[$];

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0b, expected %0b", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle past the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [2:0] btype, input logic [3:0] ph);
    @(negedge clk);
    bus.sampleValid = valid;
    bus.bloodType   = btype;
    bus.bloodPH     = ph;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    dirVecs = '{
      '{3'b000, 4'd7, 1'b0}, '{3'b000, 4'd6, 1'b1}, '{3'b001, 4'd6, 1'b1},
      '{3'b000, 4'd8, 1'b0}, '{3'b000, 4'd9, 1'b1}, '{3'b011, 4'd9, 1'b1},
      '{3'b010, 4'd7, 1'b0}, '{3'b010, 4'd6, 1'b1}, '{3'b010, 4'd8, 1'b0},
      '{3'b100, 4'd7, 1'b0}, '{3'b100, 4'd5, 1'b1}, '{3'b100, 4'd6, 1'b0},
      '{3'b100, 4'd8, 1'b1}, '{3'b101, 4'd7, 1'b0},
      '{3'b110, 4'd7, 1'b0}, '{3'b110, 4'd5, 1'b1}, '{3'b111, 4'd6, 1'b0},
      '{3'b111, 4'd8, 1'b1}
    };
    streamVecs = '{
      '{3'b010, 4'd7, 1'b0}, '{3'b100, 4'd8, 1'b1},
      '{3'b110, 4'd6, 1'b0}, '{3'b001, 4'd9, 1'b1}
    };

    rst_n           = 1'b0;
    bus.sampleValid = 1'b1;
    bus.bloodType   = 3'b000;
    bus.bloodPH     = 4'd6;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", bus.resultValid, 1'b0);
    checkOutput("reset_abn", bus.bloodAbnormality, 1'b0);

    // Releasing reset with the AB pH 6 sample still presented: result one edge later.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_valid", bus.resultValid, 1'b1);
    checkOutput("post_reset_abn", bus.bloodAbnormality, 1'b1);

    foreach (dirVecs[i]) begin
      applyStimulus(1'b1, dirVecs[i].btype, dirVecs[i].ph);
      checkOutput($sformatf("dir%0d_valid", i), bus.resultValid, 1'b1);
      checkOutput($sformatf("dir%0d_type%03b_ph%0d", i, dirVecs[i].btype, dirVecs[i].ph),
                  bus.bloodAbnormality, dirVecs[i].exp_abn);
    end

    for (int t = 0; t < 8; t++) begin
      applyStimulus(1'b1, 3'(t), 4'd0);
      checkOutput($sformatf("sweep_type%0d_ph0", t), bus.bloodAbnormality, 1'b1);
      applyStimulus(1'b1, 3'(t), 4'd15);
      checkOutput($sformatf("sweep_type%0d_ph15", t), bus.bloodAbnormality, 1'b1);
    end

    applyStimulus(1'b0, 3'b000, 4'd7);
    checkOutput("gap_valid", bus.resultValid, 1'b0);

    foreach (streamVecs[i]) begin
      applyStimulus(1'b1, streamVecs[i].btype, streamVecs[i].ph);
      checkOutput($sformatf("stream%0d_valid", i), bus.resultValid, 1'b1);
      checkOutput($sformatf("stream%0d_abn", i), bus.bloodAbnormality, streamVecs[i].exp_abn);
    end

    // Idle inputs would classify as normal, so a held 1 shows the flag did not follow them.
    applyStimulus(1'b0, 3'b000, 4'd7);
    checkOutput("idle1_valid", bus.resultValid, 1'b0);
    checkOutput("idle1_hold", bus.bloodAbnormality, 1'b1);
    applyStimulus(1'b0, 3'b100, 4'd6);
    checkOutput("idle2_valid", bus.resultValid, 1'b0);
    checkOutput("idle2_hold", bus.bloodAbnormality, 1'b1);

    applyStimulus(1'b1, 3'b000, 4'd9);
    checkOutput("pre_async_valid", bus.resultValid, 1'b1);
    checkOutput("pre_async_abn", bus.bloodAbnormality, 1'b1);

    @(negedge clk);
    bus.sampleValid = 1'b1;
    bus.bloodType   = 3'b110;
    bus.bloodPH     = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", bus.resultValid, 1'b0);
    checkOutput("async_rst_abn", bus.bloodAbnormality, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_valid", bus.resultValid, 1'b0);
    checkOutput("rst_held_abn", bus.bloodAbnormality, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'b100, 4'd7);
    checkOutput("recover_valid", bus.resultValid, 1'b1);
    checkOutput("recover_abn", bus.bloodAbnormality, 1'b0);
    applyStimulus(1'b1, 3'b010, 4'd3);
    checkOutput("recover2_abn", bus.bloodAbnormality, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
